// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the tile pooling downsampler.
package ov7670_pkg;

    typedef enum logic {POOL_MEAN = 1'b0, POOL_BIN = 1'b1} pool_mode_t;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} pool_state_t;

    // Width that holds the sum of one full tile without overflow.
    function automatic int acc_width(input int pix_w, input int tw, input int th);
        return pix_w + $clog2(tw * th);
    endfunction

endpackage

// File: rtl/tile_pool_acc_row.sv
// One row of per-tile accumulators, indexed by tile column.
// sum is always acc[idx] + pix, so the emitting pixel never needs a write.
module tile_pool_acc_row
    import ov7670_pkg::*;
#(
    parameter int N     = 28,
    parameter int PIX_W = 8,
    parameter int ACC_W = acc_width(8, 8, 8),
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [PIX_W-1:0] pix,
    input  logic             init,
    input  logic             add,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] acc_q [N];

    assign sum = acc_q[idx] + ACC_W'(pix);

    // First pixel of a tile seeds the entry; later pixels accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) acc_q[i] <= '0;
        end else if (init) begin
            acc_q[idx] <= ACC_W'(pix);
        end else if (add) begin
            acc_q[idx] <= sum;
        end
    end

endmodule

// File: rtl/tile_pool_downsampler.sv
// Crops a raster pixel stream and reduces each tile of the window to one
// word (mean or threshold) written to the LeNet input memory.
module tile_pool_downsampler
    import ov7670_pkg::*;
#(
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter int          TILE_W    = 8,
    parameter int          TILE_H    = 8,
    parameter int          OUT_W     = 28,
    parameter int          OUT_H     = 28,
    parameter int          PIX_W     = 8,
    parameter int          OUT_D_W   = 8,
    parameter int unsigned THRESHOLD = 'b01100000000000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              arm,
    input  logic                              cont,
    input  logic                              mode,
    input  logic                              invert,
    input  logic [$clog2(SCREEN_W)-1:0]       x0,
    input  logic [$clog2(SCREEN_H)-1:0]       y0,
    input  logic                              pix_valid,
    input  logic                              pix_sof,
    input  logic [PIX_W-1:0]                  pix_data,
    output logic                              out_we,
    output logic [$clog2(OUT_W*OUT_H)-1:0]    out_addr,
    output logic [OUT_D_W-1:0]                out_data,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    output logic                              abort
);

    localparam int XW     = $clog2(SCREEN_W);
    localparam int YW     = $clog2(SCREEN_H);
    localparam int ACC_W  = acc_width(PIX_W, TILE_W, TILE_H);
    localparam int ADDR_W = $clog2(OUT_W * OUT_H);
    localparam int TXW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int TWL    = $clog2(TILE_W);
    localparam int THL    = $clog2(TILE_H);
    localparam int WIN_W  = OUT_W * TILE_W;
    localparam int WIN_H  = OUT_H * TILE_H;

    pool_state_t          state_q;
    logic [XW-1:0]        x_q, x0_q, cx, cx0, nx;
    logic [YW-1:0]        y_q, y0_q, cy, cy0, ny;
    pool_mode_t           mode_q, cmode;
    logic                 inv_q, cinv;
    logic                 out_we_q, done_q, cfg_err_q, abort_q;
    logic [ADDR_W-1:0]    out_addr_q, addr;
    logic [OUT_D_W-1:0]   out_data_q, sample;
    logic                 sof_take, cfg_ok, start, proc, in_win, first, last, emit, fin;
    logic                 acc_init, acc_add;
    logic [ACC_W-1:0]     sum;
    int                   dx, dy, ix, iy, tx, ty;

    // A SOF pixel is itself pixel (0,0) of the new frame, so it is processed
    // with the freshly presented configuration rather than the latched one.
    always_comb begin
        sof_take = pix_valid && pix_sof && (state_q != IDLE);
        cfg_ok   = (int'(x0) + WIN_W <= SCREEN_W) && (int'(y0) + WIN_H <= SCREEN_H);
        start    = sof_take && cfg_ok;
        proc     = pix_valid && (start || (state_q == RUN && !sof_take));
        cx       = start ? '0 : x_q;
        cy       = start ? '0 : y_q;
        cx0      = start ? x0 : x0_q;
        cy0      = start ? y0 : y0_q;
        cmode    = start ? pool_mode_t'(mode) : mode_q;
        cinv     = start ? invert : inv_q;
        dx       = int'(cx) - int'(cx0);
        dy       = int'(cy) - int'(cy0);
        in_win   = (dx >= 0) && (dx < WIN_W) && (dy >= 0) && (dy < WIN_H);
        ix       = dx & (TILE_W - 1);
        iy       = dy & (TILE_H - 1);
        tx       = dx >> TWL;
        ty       = dy >> THL;
        first    = in_win && (ix == 0) && (iy == 0);
        last     = in_win && (ix == TILE_W - 1) && (iy == TILE_H - 1);
        emit     = proc && last;
        fin      = emit && (tx == OUT_W - 1) && (ty == OUT_H - 1);
        acc_init = proc && first;
        acc_add  = proc && in_win && !first && !last;
        addr     = ADDR_W'(ty * OUT_W + tx);
        nx       = (int'(cx) == SCREEN_W - 1) ? '0 : cx + 1'b1;
        ny       = cy;
        if (int'(cx) == SCREEN_W - 1) ny = (int'(cy) == SCREEN_H - 1) ? '0 : cy + 1'b1;
    end

    // Reduce the completed tile; sum is ACC_W = PIX_W + log2(tile area) bits,
    // so its top OUT_D_W bits are the mean already truncated to output width.
    always_comb begin
        if (cmode == POOL_BIN) sample = (sum >= ACC_W'(THRESHOLD)) ? '1 : '0;
        else                   sample = sum[ACC_W-1 -: OUT_D_W];
        sample = sample ^ {OUT_D_W{cinv}};
    end

    tile_pool_acc_row #(
        .N(OUT_W), .PIX_W(PIX_W), .ACC_W(ACC_W), .IDX_W(TXW)
    ) u_acc (
        .clk(clk), .rst_n(rst_n), .idx(TXW'(tx)), .pix(pix_data),
        .init(acc_init), .add(acc_add), .sum(sum)
    );

    // FSM, raster counters, configuration latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            mode_q     <= POOL_MEAN;
            inv_q      <= 1'b0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            out_we_q  <= emit;
            done_q    <= fin;
            cfg_err_q <= sof_take && !cfg_ok;
            abort_q   <= sof_take && (state_q == RUN);
            if (emit) begin
                out_addr_q <= addr;
                out_data_q <= sample;
            end
            if (start) begin
                x0_q   <= x0;
                y0_q   <= y0;
                mode_q <= pool_mode_t'(mode);
                inv_q  <= invert;
            end
            if (proc) begin
                x_q <= nx;
                y_q <= ny;
            end
            case (state_q)
                IDLE:    if (arm) state_q <= ARMED;
                ARMED:   if (start) state_q <= RUN;
                RUN: begin
                    if (sof_take)  state_q <= cfg_ok ? RUN : ARMED;
                    else if (fin)  state_q <= cont ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_tile_pool_downsampler.sv
// Directed bench on a shrunk geometry: 20x8 frame, 4x2 tiles, 4x3 output grid.
module tb_tile_pool_downsampler;

    localparam int SW = 20, SH = 8, TW = 4, TH = 2, OW = 4, OH = 3;
    localparam int NW = OW * OH;
    localparam int FRAME = SW * SH;

    logic       clk, rst_n, arm, cont, mode, invert, pix_valid, pix_sof;
    logic [4:0] x0;
    logic [2:0] y0;
    logic [7:0] pix_data, out_data;
    logic [3:0] out_addr;
    logic       out_we, busy, done, cfg_err, abort;

    int n_chk = 0, n_fail = 0;

    // observation counters, written only by the monitor
    int         wr_n = 0, done_n = 0, abort_n = 0, cfg_n = 0, idle_n = 0;
    int         done_bad = 0, busy_bad = 0;
    logic [3:0] wa [1024];
    logic [7:0] wd [1024];

    tile_pool_downsampler #(
        .SCREEN_W(SW), .SCREEN_H(SH), .TILE_W(TW), .TILE_H(TH),
        .OUT_W(OW), .OUT_H(OH), .PIX_W(8), .OUT_D_W(8), .THRESHOLD(768)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .cont(cont), .mode(mode),
        .invert(invert), .x0(x0), .y0(y0), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_data(pix_data), .out_we(out_we),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
        .cfg_err(cfg_err), .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sample registered outputs midway between rising edges
    always @(negedge clk) begin
        if (out_we) begin
            wa[wr_n % 1024] = out_addr;
            wd[wr_n % 1024] = out_data;
            wr_n++;
        end
        if (done) begin
            done_n++;
            if (!(out_we && out_addr == 4'(NW - 1))) done_bad++;
            if (busy && !cont) busy_bad++;
        end
        if (abort)   abort_n++;
        if (cfg_err) cfg_n++;
        if (!busy)   idle_n++;
    end

    function automatic logic [7:0] pix_of(input int pat, input int pval, input int i);
        int x;
        x = i % SW;
        case (pat)
            1:       return 8'(x);
            2:       return ((x / TW) % 2 == 0) ? 8'h61 : 8'h5F;
            default: return 8'(pval);
        endcase
    endfunction

    task automatic drive(input int pat, input int pval, input int npix);
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_data  = pix_of(pat, pval, i);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_sof   = 1'b0;
        end
    endtask

    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        n_chk++; if (out_we !== 1'b0)    begin n_fail++; $display("FAIL reset_we got %b want 0", out_we); end
        n_chk++; if (out_addr !== 4'd0)  begin n_fail++; $display("FAIL reset_addr got %0d want 0", out_addr); end
        n_chk++; if (out_data !== 8'd0)  begin n_fail++; $display("FAIL reset_data got %0h want 0", out_data); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if ({done, cfg_err, abort} !== 3'b000)
            begin n_fail++; $display("FAIL reset_pulses got %b want 000", {done, cfg_err, abort}); end
    endtask

    task automatic test_const();
        int b, d;
        b = wr_n; d = done_n;
        x0 = 0; y0 = 0; mode = 0; invert = 0; cont = 0;
        arm_pulse();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL armed_busy got %b want 1", busy); end
        drive(0, 'h80, FRAME);
        idle(3);
        n_chk++; if (wr_n - b !== NW) begin n_fail++; $display("FAIL const_count got %0d want %0d", wr_n - b, NW); end
        for (int k = 0; k < NW; k++) begin
            n_chk++;
            if (wa[(b + k) % 1024] !== 4'(k) || wd[(b + k) % 1024] !== 8'h80) begin
                n_fail++;
                $display("FAIL const_word%0d got addr %0d data %0h want addr %0d data 80",
                         k, wa[(b + k) % 1024], wd[(b + k) % 1024], k);
            end
        end
        n_chk++; if (done_n - d !== 1) begin n_fail++; $display("FAIL const_done got %0d want 1", done_n - d); end
        n_chk++; if (done_bad !== 0)   begin n_fail++; $display("FAIL done_with_last_write got %0d bad want 0", done_bad); end
        n_chk++; if (busy_bad !== 0)   begin n_fail++; $display("FAIL busy_at_done got %0d bad want 0", busy_bad); end
        n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL const_idle got busy %b want 0", busy); end
    endtask

    task automatic test_binary();
        int b;
        logic [7:0] exp;
        for (int inv = 0; inv < 2; inv++) begin
            b = wr_n;
            x0 = 0; y0 = 0; mode = 1; invert = inv[0];
            arm_pulse();
            drive(2, 0, FRAME);
            idle(3);
            n_chk++; if (wr_n - b !== NW) begin n_fail++; $display("FAIL bin%0d_count got %0d want %0d", inv, wr_n - b, NW); end
            for (int k = 0; k < NW; k++) begin
                exp = (((k % OW) % 2 == 0) ^ (inv == 1)) ? 8'hFF : 8'h00;
                n_chk++;
                if (wd[(b + k) % 1024] !== exp) begin
                    n_fail++;
                    $display("FAIL bin%0d_word%0d got %0h want %0h", inv, k, wd[(b + k) % 1024], exp);
                end
            end
        end
        mode = 0; invert = 0;
    endtask

    task automatic test_offset();
        int b;
        b = wr_n;
        x0 = 2; y0 = 1;
        arm_pulse();
        drive(1, 0, FRAME);
        idle(3);
        n_chk++; if (wr_n - b !== NW) begin n_fail++; $display("FAIL offset_count got %0d want %0d", wr_n - b, NW); end
        for (int k = 0; k < NW; k++) begin
            n_chk++;
            if (wa[(b + k) % 1024] !== 4'(k) || wd[(b + k) % 1024] !== 8'(3 + 4 * (k % OW))) begin
                n_fail++;
                $display("FAIL offset_word%0d got addr %0d data %0d want addr %0d data %0d",
                         k, wa[(b + k) % 1024], wd[(b + k) % 1024], k, 3 + 4 * (k % OW));
            end
        end
    endtask

    task automatic test_cfg_err();
        int b, c, d;
        b = wr_n; c = cfg_n; d = done_n;
        x0 = 5; y0 = 0;
        arm_pulse();
        drive(0, 'h80, FRAME);
        idle(2);
        n_chk++; if (cfg_n - c !== 1) begin n_fail++; $display("FAIL cfg_err_pulse got %0d want 1", cfg_n - c); end
        n_chk++; if (wr_n - b !== 0)  begin n_fail++; $display("FAIL cfg_err_writes got %0d want 0", wr_n - b); end
        n_chk++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL cfg_err_busy got %b want 1", busy); end
        x0 = 0;
        drive(0, 'h30, FRAME);
        idle(3);
        n_chk++; if (wr_n - b !== NW) begin n_fail++; $display("FAIL cfg_retry_count got %0d want %0d", wr_n - b, NW); end
        n_chk++; if (wd[(b + NW - 1) % 1024] !== 8'h30)
            begin n_fail++; $display("FAIL cfg_retry_data got %0h want 30", wd[(b + NW - 1) % 1024]); end
        n_chk++; if (done_n - d !== 1) begin n_fail++; $display("FAIL cfg_retry_done got %0d want 1", done_n - d); end
    endtask

    task automatic test_abort();
        int b, a, d;
        logic [7:0] exp;
        b = wr_n; a = abort_n; d = done_n;
        x0 = 0; y0 = 0;
        arm_pulse();
        drive(0, 'h40, 100);
        drive(0, 'h20, FRAME);
        idle(3);
        n_chk++; if (abort_n - a !== 1) begin n_fail++; $display("FAIL abort_pulse got %0d want 1", abort_n - a); end
        n_chk++; if (wr_n - b !== 8 + NW) begin n_fail++; $display("FAIL abort_count got %0d want %0d", wr_n - b, 8 + NW); end
        for (int k = 0; k < 8 + NW; k++) begin
            exp = (k < 8) ? 8'h40 : 8'h20;
            n_chk++;
            if (wa[(b + k) % 1024] !== 4'((k < 8) ? k : k - 8) || wd[(b + k) % 1024] !== exp) begin
                n_fail++;
                $display("FAIL abort_word%0d got addr %0d data %0h want addr %0d data %0h",
                         k, wa[(b + k) % 1024], wd[(b + k) % 1024], (k < 8) ? k : k - 8, exp);
            end
        end
        n_chk++; if (done_n - d !== 1) begin n_fail++; $display("FAIL abort_done got %0d want 1", done_n - d); end
    endtask

    task automatic test_back_to_back();
        int b, d, il;
        b = wr_n; d = done_n;
        cont = 1;
        arm_pulse();
        il = idle_n;
        drive(0, 'h11, FRAME);
        drive(0, 'h22, FRAME);
        idle(3);
        n_chk++; if (done_n - d !== 2) begin n_fail++; $display("FAIL b2b_done got %0d want 2", done_n - d); end
        n_chk++; if (idle_n - il !== 0) begin n_fail++; $display("FAIL b2b_busy_low got %0d cycles want 0", idle_n - il); end
        n_chk++; if (wr_n - b !== 2 * NW) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", wr_n - b, 2 * NW); end
        n_chk++; if (wd[(b + NW) % 1024] !== 8'h22 || wa[(b + NW) % 1024] !== 4'd0)
            begin n_fail++; $display("FAIL b2b_second_first got addr %0d data %0h want addr 0 data 22",
                                     wa[(b + NW) % 1024], wd[(b + NW) % 1024]); end
        cont = 0;
    endtask

    task automatic test_reset_mid();
        // still ARMED after the continuous-mode test
        drive(0, 'h55, 28);
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        n_chk++; if (out_we !== 1'b1 || out_addr !== 4'd1 || out_data !== 8'h55)
            begin n_fail++; $display("FAIL pre_reset_write got we %b addr %0d data %0h want 1 1 55",
                                     out_we, out_addr, out_data); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (out_we !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_we got %b want 0", out_we); end
        n_chk++; if (out_addr !== 4'd0) begin n_fail++; $display("FAIL rst_mid_addr got %0d want 0", out_addr); end
        n_chk++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL rst_mid_data got %0h want 0", out_data); end
        n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        n_chk++; if (busy !== 1'b0 || out_we !== 1'b0)
            begin n_fail++; $display("FAIL post_reset got busy %b we %b want 0 0", busy, out_we); end
    endtask

    initial begin
        rst_n = 1'b0; arm = 0; cont = 0; mode = 0; invert = 0;
        x0 = 0; y0 = 0; pix_valid = 0; pix_sof = 0; pix_data = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_const();
        test_binary();
        test_offset();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
